// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - display data/control bundle between counter logic and the digit scanner
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 6
);
    logic [4*NUM_DIGITS-1:0] in_data;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    en;
    logic                    lz_blank;
    logic [7:0]              seg_data;
    logic [NUM_DIGITS-1:0]   seg_position;
    logic                    frame_start;
`ifdef SEG_BLINK_EN
    logic [NUM_DIGITS-1:0]   blink_mask;

    modport master (
        output in_data, dp_in, en, lz_blank, blink_mask,
        input  seg_data, seg_position, frame_start
    );
    modport slave (
        input  in_data, dp_in, en, lz_blank, blink_mask,
        output seg_data, seg_position, frame_start
    );
`else
    modport master (
        output in_data, dp_in, en, lz_blank,
        input  seg_data, seg_position, frame_start
    );
    modport slave (
        input  in_data, dp_in, en, lz_blank,
        output seg_data, seg_position, frame_start
    );
`endif
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed 7-segment scanner with per-frame input snapshot
// Blinking of masked digits is compiled in when SEG_BLINK_EN is defined.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 8000
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic             clk,
    input  logic             rst,
    seg_scan_driver_if.slave disp
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shd_data_q, shd_data_d;
    logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   pos_q, pos_d;
    logic                    fs_q, fs_d;

    logic                    tick;
    logic                    frame_tick;
    logic [IDX_W-1:0]        nxt;
    logic [4*NUM_DIGITS-1:0] src_data;
    logic [NUM_DIGITS-1:0]   src_dp;
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic                    lz_run;
    logic [3:0]              digit;
    logic                    blank;

`ifdef SEG_BLINK_EN
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES);

    logic [NUM_DIGITS-1:0] shd_blink_q, shd_blink_d;
    logic [NUM_DIGITS-1:0] src_blink;
    logic [FC_W-1:0]       fcnt_q, fcnt_d;
    logic                  phase_q, phase_d;
    logic                  phase_eff;
`endif

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'd0:    seg_code = 7'b1111110;
            4'd1:    seg_code = 7'b0110000;
            4'd2:    seg_code = 7'b1101101;
            4'd3:    seg_code = 7'b1111001;
            4'd4:    seg_code = 7'b0110011;
            4'd5:    seg_code = 7'b1011011;
            4'd6:    seg_code = 7'b0011111;
            4'd7:    seg_code = 7'b1110000;
            4'd8:    seg_code = 7'b1111111;
            4'd9:    seg_code = 7'b1110011;
            default: seg_code = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shd_data_d = shd_data_q;
        shd_dp_d   = shd_dp_q;
        seg_d      = seg_q;
        pos_d      = pos_q;
        fs_d       = 1'b0;
        lead_zero  = '0;
        lz_run     = 1'b1;

        tick       = disp.en && (cnt_q == CNT_LAST);
        nxt        = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        frame_tick = tick && (nxt == '0);

        // Digit 0 of a new frame renders straight from the inputs being captured.
        src_data = frame_tick ? disp.in_data : shd_data_q;
        src_dp   = frame_tick ? disp.dp_in   : shd_dp_q;

        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lz_run       = lz_run & (src_data[4*k +: 4] == 4'd0);
            lead_zero[k] = lz_run;
        end

        digit = src_data[{nxt, 2'b00} +: 4];
        blank = disp.lz_blank && (nxt != '0) && lead_zero[nxt];

`ifdef SEG_BLINK_EN
        shd_blink_d = shd_blink_q;
        fcnt_d      = fcnt_q;
        phase_d     = phase_q;
        phase_eff   = phase_q;
        src_blink   = frame_tick ? disp.blink_mask : shd_blink_q;
        if (frame_tick) begin
            shd_blink_d = disp.blink_mask;
            if (fcnt_q == FC_LAST) begin
                phase_eff = ~phase_q;
                fcnt_d    = FC_W'(1);
            end else begin
                fcnt_d = fcnt_q + FC_W'(1);
            end
            phase_d = phase_eff;
        end
        blank = blank || (phase_eff && src_blink[nxt]);
`endif

        if (!disp.en) begin
            cnt_d = '0;
            idx_d = IDX_LAST;
            seg_d = '0;
            pos_d = '1;
        end else begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
            if (tick) begin
                idx_d = nxt;
                if (frame_tick) begin
                    shd_data_d = disp.in_data;
                    shd_dp_d   = disp.dp_in;
                    fs_d       = 1'b1;
                end
                seg_d = blank ? 8'h00 : {seg_code(digit), src_dp[nxt]};
                pos_d = ~(NUM_DIGITS'(1) << nxt);
            end
        end
    end

    // idx resets to the last position so the first tick wraps onto digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= IDX_LAST;
            shd_data_q <= '0;
            shd_dp_q   <= '0;
            seg_q      <= '0;
            pos_q      <= '1;
            fs_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shd_data_q <= shd_data_d;
            shd_dp_q   <= shd_dp_d;
            seg_q      <= seg_d;
            pos_q      <= pos_d;
            fs_q       <= fs_d;
        end
    end

`ifdef SEG_BLINK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shd_blink_q <= '0;
            fcnt_q      <= '0;
            phase_q     <= 1'b0;
        end else begin
            shd_blink_q <= shd_blink_d;
            fcnt_q      <= fcnt_d;
            phase_q     <= phase_d;
        end
    end
`endif

    assign disp.seg_data     = seg_q;
    assign disp.seg_position = pos_q;
    assign disp.frame_start  = fs_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - randomized self-checking bench for seg_scan_driver against a cycle-count model
module tb_seg_scan_driver;
    localparam int N  = 6;
    localparam int SD = 4;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b0011111, 7'b1110000,
        7'b1111111, 7'b1110011, 7'b0000000, 7'b0000000,
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
    };

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    int          m_run;
    logic [23:0] m_snap;
    logic [5:0]  m_dp;
    logic [5:0]  m_pos;
    logic [7:0]  m_seg;
    logic        m_fs;

    seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] render(input logic [23:0] d, input logic [5:0] dp,
                                          input logic lz, input int k);
        bit lead;
        lead = 1'b1;
        for (int j = N - 1; j >= k; j--)
            if (d[4*j +: 4] != 4'd0) lead = 1'b0;
        if (lz && k != 0 && lead) return 8'h00;
        return {SEG_TBL[d[4*k +: 4]], dp[k]};
    endfunction

    task automatic model_reset();
        m_run  = 0;
        m_snap = '0;
        m_dp   = '0;
        m_pos  = '1;
        m_seg  = '0;
        m_fs   = 1'b0;
    endtask

    // Outputs change on every SD-th enabled edge; slot number modulo N is the digit.
    task automatic model_edge();
        int k;
        m_fs = 1'b0;
        if (!bus.en) begin
            m_run = 0;
            m_pos = '1;
            m_seg = '0;
        end else begin
            m_run++;
            if (m_run % SD == 0) begin
                k = (m_run / SD - 1) % N;
                if (k == 0) begin
                    m_snap = bus.in_data;
                    m_dp   = bus.dp_in;
                end
                m_pos = ~(6'b000001 << k);
                m_seg = render(m_snap, m_dp, bus.lz_blank, k);
                m_fs  = (k == 0);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check("seg_data", 32'(bus.seg_data), 32'(m_seg));
        check("seg_position", 32'(bus.seg_position), 32'(m_pos));
        check("frame_start", 32'(bus.frame_start), 32'(m_fs));
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.frame_start && n < 60);
        check("frame_start_seen", 32'(bus.frame_start), 32'd1);
    endtask

    task automatic scan_frame(input logic [47:0] exp, input bit change_mid);
        logic [5:0] p;
        for (int s = 0; s < N; s++) begin
            p = 6'b111111 ^ (6'b000001 << s);
            check("lit_pos", 32'(bus.seg_position), 32'(p));
            check("lit_data", 32'(bus.seg_data), 32'(exp[8*s +: 8]));
            check("lit_fs", 32'(bus.frame_start), (s == 0) ? 32'd1 : 32'd0);
            if (change_mid && s == 2) bus.in_data = 24'h999999;
            repeat (SD) step();
        end
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.in_data  = 24'h123456;
        bus.dp_in    = '0;
        bus.en       = 1'b1;
        bus.lz_blank = 1'b0;
        model_reset();

        #1;
        check("reset_seg", 32'(bus.seg_data), 32'h0);
        check("reset_pos", 32'(bus.seg_position), 32'h3f);
        check("reset_fs", 32'(bus.frame_start), 32'h0);
        repeat (3) step();
        rst = 1'b0;

        wait_fs(n);
        check("first_frame_latency", n, 4);
        scan_frame({8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'h3E}, 1'b1);
        scan_frame({6{8'hE6}}, 1'b0);

        bus.lz_blank = 1'b1;
        bus.in_data  = 24'h000405;
        wait_fs(n);
        scan_frame({8'h00, 8'h00, 8'h00, 8'h66, 8'hFC, 8'hB6}, 1'b0);
        bus.in_data = 24'h000000;
        wait_fs(n);
        scan_frame({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFC}, 1'b0);

        bus.lz_blank = 1'b0;
        bus.in_data  = 24'h123456;
        bus.dp_in    = 6'b000100;
        wait_fs(n);
        scan_frame({8'h60, 8'hDA, 8'hF2, 8'h67, 8'hB6, 8'h3E}, 1'b0);

        repeat (6) step();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("midreset_seg", 32'(bus.seg_data), 32'h0);
        check("midreset_pos", 32'(bus.seg_position), 32'h3f);
        repeat (2) step();
        rst = 1'b0;
        wait_fs(n);
        check("reset_restart_latency", n, 4);

        repeat (5) step();
        bus.en = 1'b0;
        step();
        check("dis_seg", 32'(bus.seg_data), 32'h0);
        check("dis_pos", 32'(bus.seg_position), 32'h3f);
        repeat (7) step();
        bus.en = 1'b1;
        wait_fs(n);
        check("enable_restart_latency", n, 4);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0)
                bus.in_data = 24'($urandom()) >> (4 * $urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) bus.dp_in = 6'($urandom());
            if ($urandom_range(0, 31) == 0) bus.lz_blank = ~bus.lz_blank;
            if ($urandom_range(0, 99) == 0) bus.en = 1'b0;
            else if (!bus.en && $urandom_range(0, 3) == 0) bus.en = 1'b1;
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                model_reset();
                step();
                rst = 1'b0;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
